imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the single-cycle core's instruction memory at runtime instead of through `initial` contents. It accepts a byte stream with a length header, packs bytes little-endian into 32-bit RISC-V instructions, and issues one write per word on the instruction-memory write port. `busy` holds the core's fetch stage idle while loading is in progress.

## Interface
Parameters:
- `ADDR_W`, default 10. Width of the instruction-memory word address.
- `DEPTH`, default 1024. Number of instruction words; must equal 2^`ADDR_W`.

Ports:
- `clk` input, 1 bit. Single clock.
- `rst_n` input, 1 bit. Reset, synchronous and active-low.
- `start` input, 1 bit. One-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `in_valid` input, 1 bit. Byte-stream valid.
- `in_data` input, 8 bits. Byte-stream data.
- `in_ready` output, 1 bit. Byte-stream ready.
- `mem_we` output, 1 bit. Instruction-memory write strobe, one cycle per word.
- `mem_addr` output, `ADDR_W` bits. Word address.
- `mem_wdata` output, 32 bits. Assembled instruction.
- `busy` output, 1 bit. High in every state except IDLE and DONE.
- `done` output, 1 bit. High in DONE.
- `err` output, 1 bit. Sticky length error.

## Operation
- A byte transfers only when `in_valid && in_ready`.
- States and transitions:
  - IDLE: on `start`, go to LEN_LO.
  - LEN_LO: accept one byte as `len[7:0]`, then go to LEN_HI.
  - LEN_HI: accept one byte as `len[15:8]`.
    - If `len == 0`, go to DONE.
    - If `len > DEPTH`, set `err` and go to DONE with no writes.
    - Otherwise go to DATA.
  - DATA: accept 4 bytes into `word[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` in that order. After the 4th byte, go to WRITE.
  - WRITE: assert `mem_we` for one cycle with `mem_addr = wcnt` and `mem_wdata = word`, then increment `wcnt`.
    - If `wcnt == len-1`, go to DONE.
    - Otherwise go to DATA.
  - DONE: on `start`, clear `err` and `wcnt` and go to LEN_LO.
- `in_ready` is 1 only in LEN_LO, LEN_HI and DATA. It is 0 in IDLE, WRITE and DONE.
- Counters:
  - `wcnt` is 16 bits and starts at 0 for every load.
  - The byte index (2 bits) clears on entering DATA from LEN_HI or from WRITE.
- `start` while `busy` is ignored, with no effect on state or counters.
- `in_valid` outside the accepting states is ignored and never consumed.
- Loading `DEPTH` words writes addresses 0..`DEPTH`-1 exactly once. `mem_addr` never wraps.
- Reset mid-load:
  - Return to IDLE and clear all outputs and counters.
  - Words already written stay in memory. `done` is not asserted.
- Outputs during reset and in IDLE: `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy=0`, `done=0`, `err=0`.

## Timing
- All outputs are registered.
- `mem_we` is high the cycle after the handshake that accepted the 4th byte of a word.
- Peak throughput is one word per 5 cycles: 4 byte cycles plus 1 WRITE cycle.
- `done` rises the cycle after the last WRITE, or the cycle after the LEN_HI byte when `len == 0` or `len > DEPTH`.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises.
- `mem_addr` and `mem_wdata` are valid only while `mem_we` is high. Between writes they hold their last values.
- Core handoff: the core's state/PC logic must not fetch while `busy` is high. The existing fetch takes `instruction <= memfile[pc]` when `state == 0`. Any read in the cycle after the final `mem_we` must see the new word, which needs write-first or a 1-cycle gap in the memory.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE);
  - `IMEM_ADDR_W = 10` and `IMEM_DEPTH = 1024`, shared with the instruction memory;
  - `LEN_BYTES = 2`.
- Single module with no sub-module. The byte packer is a 32-bit register indexed by the 2-bit byte counter, kept inline.

## Test plan
- Normal load:
  - Stimulus: `start`, then bytes 02 00 13 05 10 00 93 05 15 00 with `in_valid` held.
  - Required: exactly two `mem_we` pulses, addr 0 = 0x00100513 (`addi x10,x0,1`) and addr 1 = 0x00150593 (`addi x11,x10,1`).
  - Required: the 2nd pulse falls 5 cycles after the 1st; `done=1` and `busy=0` on the next cycle.
- Backpressure gaps:
  - Stimulus: same stream with `in_valid` deasserted for 3 cycles between bytes 2 and 3 of a word.
  - Required: identical writes; no byte is consumed twice.
- Zero length:
  - Stimulus: header 00 00.
  - Required: no `mem_we`, `err=0`, `done=1` one cycle after the 2nd byte.
- Oversize length:
  - Stimulus: header 01 04 (1025).
  - Required: `err=1`, `done=1`, no `mem_we`.
  - Then: a new `start` clears `err`.
- Full depth:
  - Stimulus: header 00 04 with 1024 words of pattern `word = i`.
  - Required: the last write is addr 1023 = 0x000003FF, followed by `done`.
- Reset and restart:
  - Stimulus: `rst_n=0` for 1 cycle after the 2nd byte of the 2nd word.
  - Required: all outputs 0 and state IDLE on the next cycle.
  - Then: a subsequent `start` plus full stream loads correctly from addr 0.
  - Also: `start` pulsed mid-load has no effect.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizes for the instruction-memory loader
//
// Purpose : loader state encoding plus the instruction-memory geometry that
//           the loader and the instruction memory must agree on.
// Contents: state_t enum, IMEM_ADDR_W, IMEM_DEPTH, LEN_BYTES, and small
//           state-decode helpers used to build the registered outputs.

package imem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;

    // Length header is a 16-bit little-endian word count.
    localparam int LEN_BYTES   = 2;

    // States in which the byte stream may transfer.
    function automatic logic state_accepts(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

    // The core fetch stage is held off in every state except IDLE and DONE.
    function automatic logic state_busy(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port bundle
//
// Purpose : groups the loader's byte-stream handshake and its
//           instruction-memory write port.
// Signals : in_valid/in_data/in_ready - byte stream (producer -> loader)
//           mem_we/mem_addr/mem_wdata - word write port (loader -> memory)
// Modports: master - stream producer / memory side
//           slave  - the loader itself

interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - runtime instruction-memory loader from a length-prefixed byte stream
//
// Purpose : receives a 16-bit little-endian word count followed by that many
//           32-bit little-endian instructions, and writes each word to the
//           instruction memory at consecutive addresses starting from 0.
//           busy holds the core fetch stage off while a load is running.
// Ports   : clk   - single clock
//           rst_n - synchronous active-low reset
//           start - one-cycle load request, honoured only in IDLE or DONE
//           busy  - high in every state except IDLE and DONE
//           done  - high in DONE
//           err   - sticky length error (header count exceeds DEPTH)
//           bus   - byte stream in, instruction-memory write port out
// All outputs are registered: each one is computed from the next state and
// loaded in the same flop update as the state register.

module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    imem_loader_if.slave  bus
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_n;

    logic [7:0]        len_lo;
    logic [7:0]        len_lo_n;
    logic [15:0]       len;
    logic [15:0]       len_n;
    logic [31:0]       word;
    logic [31:0]       word_n;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_n;
    logic [15:0]       wcnt;
    logic [15:0]       wcnt_n;

    // Registered outputs
    logic              err_q;
    logic              err_n;
    logic              in_ready_q;
    logic              in_ready_n;
    logic              mem_we_q;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       mem_wdata_n;
    logic              busy_q;
    logic              busy_n;
    logic              done_q;
    logic              done_n;

    logic              fire;
    logic [15:0]       hdr_len;

    // in_ready_q is exactly "current state accepts", so the handshake can use
    // the registered copy without adding a decode on the ready path.
    assign fire    = bus.in_valid && in_ready_q;

    // Full header as it stands while the high byte is on the bus.
    assign hdr_len = {bus.in_data, len_lo};

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_lo      <= '0;
            len         <= '0;
            word        <= '0;
            byte_idx    <= '0;
            wcnt        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            len_lo      <= len_lo_n;
            len         <= len_n;
            word        <= word_n;
            byte_idx    <= byte_idx_n;
            wcnt        <= wcnt_n;
            err_q       <= err_n;
            in_ready_q  <= in_ready_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        len_lo_n    = len_lo;
        len_n       = len;
        word_n      = word;
        byte_idx_n  = byte_idx;
        wcnt_n      = wcnt;
        err_n       = err_q;
        mem_we_n    = 1'b0;
        // Address and data hold their last values between writes.
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LEN_LO;
                    wcnt_n  = '0;
                    err_n   = 1'b0;
                end
            end

            LEN_LO: begin
                if (fire) begin
                    len_lo_n = bus.in_data;
                    state_n  = LEN_HI;
                end
            end

            LEN_HI: begin
                if (fire) begin
                    len_n = hdr_len;
                    if (hdr_len == 16'd0) begin
                        state_n = DONE;
                    end else if (17'(hdr_len) > DEPTH_L) begin
                        // Refuse the whole image rather than wrap the address.
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        byte_idx_n = 2'd0;
                        state_n    = DATA;
                    end
                end
            end

            DATA: begin
                if (fire) begin
                    word_n[{byte_idx, 3'b000} +: 8] = bus.in_data;
                    byte_idx_n                      = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        // Launch the write now so mem_we/addr/wdata are all
                        // registered and present together in WRITE.
                        state_n     = WRITE;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = wcnt[ADDR_W-1:0];
                        mem_wdata_n = {bus.in_data, word[23:0]};
                    end
                end
            end

            WRITE: begin
                wcnt_n = wcnt + 16'd1;
                if (wcnt == len - 16'd1) begin
                    state_n = DONE;
                end else begin
                    byte_idx_n = 2'd0;
                    state_n    = DATA;
                end
            end

            DONE: begin
                if (start) begin
                    err_n   = 1'b0;
                    wcnt_n  = '0;
                    state_n = LEN_LO;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = state_accepts(state_n);
        busy_n     = state_busy(state_n);
        done_n     = (state_n == DONE);
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;
    import imem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic err;

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(
        .ADDR_W (10),
        .DEPTH  (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled on the falling edge.
    logic [9:0]  log_addr [0:2047];
    logic [31:0] log_data [0:2047];
    int          log_cyc  [0:2047];
    int          nwr = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (nwr < 2048) begin
                log_addr[nwr] = bus.mem_addr;
                log_data[nwr] = bus.mem_wdata;
                log_cyc[nwr]  = cyc;
            end
            nwr = nwr + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return on the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bus.in_ready === 1'b1) got = 1'b1;
            @(negedge clk);
        end
        check("send_byte", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_done(output int dc);
        for (int i = 0; i < 8000; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        check("done_timeout", {31'b0, done}, 32'd1);
        dc = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  {31'b0, bus.in_ready}, 32'd0);
        check({tag, "_mem_we"},    {31'b0, bus.mem_we},   32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),     32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,         32'd0);
        check({tag, "_busy"},      {31'b0, busy},         32'd0);
        check({tag, "_done"},      {31'b0, done},         32'd0);
        check({tag, "_err"},       {31'b0, err},          32'd0);
    endtask

    logic [7:0] prog [10];
    int         base;
    int         dc;
    int         bad;
    logic [31:0] w;

    initial begin
        prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Valid in IDLE is ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (2) @(negedge clk);
        check("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("idle_busy",     {31'b0, busy},         32'd0);
        bus.in_valid = 1'b0;

        // Normal load
        base = nwr;
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) send_byte(prog[i]);
        bus.in_valid = 1'b0;
        wait_done(dc);
        check("t1_nwr",   32'(nwr - base),         32'd2);
        check("t1_addr0", 32'(log_addr[base]),     32'd0);
        check("t1_data0", log_data[base],          32'h00100513);
        check("t1_addr1", 32'(log_addr[base+1]),   32'd1);
        check("t1_data1", log_data[base+1],        32'h00150593);
        check("t1_gap",   32'(log_cyc[base+1] - log_cyc[base]), 32'd5);
        check("t1_done_cyc", 32'(dc - log_cyc[base+1]), 32'd1);
        check("t1_busy_end", {31'b0, busy}, 32'd0);
        check("t1_err",      {31'b0, err},  32'd0);

        // Backpressure gap between bytes 2 and 3 of word 0
        base = nwr;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 4; i < 10; i++) send_byte(prog[i]);
        bus.in_valid = 1'b0;
        wait_done(dc);
        check("t2_nwr",   32'(nwr - base),       32'd2);
        check("t2_addr0", 32'(log_addr[base]),   32'd0);
        check("t2_data0", log_data[base],        32'h00100513);
        check("t2_addr1", 32'(log_addr[base+1]), 32'd1);
        check("t2_data1", log_data[base+1],      32'h00150593);

        // Zero length
        base = nwr;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_err",  {31'b0, err},  32'd0);
        check("t3_busy", {31'b0, busy}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (2) @(negedge clk);
        check("t3_done_in_ready", {31'b0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        check("t3_nwr", 32'(nwr - base), 32'd0);

        // Oversize length 1025
        base = nwr;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        bus.in_valid = 1'b0;
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_err",  {31'b0, err},  32'd1);
        @(negedge clk);
        check("t4_err_sticky", {31'b0, err}, 32'd1);
        check("t4_nwr", 32'(nwr - base), 32'd0);
        pulse_start();
        check("t4_err_clr",  {31'b0, err},  32'd0);
        check("t4_busy",     {31'b0, busy}, 32'd1);
        check("t4_done_clr", {31'b0, done}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        check("t4_done2", {31'b0, done}, 32'd1);

        // Full depth, word i = i
        base = nwr;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i);
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            send_byte(w[31:24]);
        end
        bus.in_valid = 1'b0;
        wait_done(dc);
        check("t5_nwr", 32'(nwr - base), 32'd1024);
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (log_addr[base+k] !== 10'(k) || log_data[base+k] !== 32'(k)) bad++;
        end
        check("t5_bad_words", 32'(bad), 32'd0);
        check("t5_last_addr", 32'(log_addr[base+1023]), 32'd1023);
        check("t5_last_data", log_data[base+1023],      32'h000003FF);
        check("t5_done_cyc",  32'(dc - log_cyc[base+1023]), 32'd1);
        check("t5_err",       {31'b0, err}, 32'd0);

        // Mid-load start ignored, then reset mid-load
        base = nwr;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        pulse_start();
        check("t6_busy_mid",  {31'b0, busy},         32'd1);
        check("t6_ready_mid", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 2; i < 8; i++) send_byte(prog[i]);
        bus.in_valid = 1'b0;
        check("t6_nwr_pre",  32'(nwr - base),     32'd1);
        check("t6_addr_pre", 32'(log_addr[base]), 32'd0);
        check("t6_data_pre", log_data[base],      32'h00100513);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("t6_rst");
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        check("t6_idle_done", {31'b0, done}, 32'd0);
        base = nwr;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(prog[i]);
        bus.in_valid = 1'b0;
        wait_done(dc);
        check("t6_nwr",   32'(nwr - base),       32'd2);
        check("t6_addr0", 32'(log_addr[base]),   32'd0);
        check("t6_data0", log_data[base],        32'h00100513);
        check("t6_addr1", 32'(log_addr[base+1]), 32'd1);
        check("t6_data1", log_data[base+1],      32'h00150593);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
